// File: rtl/results_dma_tx.sv
// results_dma_tx
//   Packs a stream of 9-bit GBDT results into DMA_RATE-bit beats.
//   G = DMA_RATE/9 results are packed per beat, with lane 0 in the LSBs.
//   CYCLES_NUM beats make one frame.
//
// Parameters
//   DMA_RATE   : beat width in bits, a multiple of 9 (default 144)
//   CYCLES_NUM : beats per frame (default 16)
//
// Ports
//   gbdt_clk, gbdt_rst_n : clock, asynchronous active-low reset
//   start                : frame start request, looked at in IDLE only
//   res_data/res_valid   : result stream in; res_ready is high while filling a beat
//   dma_data/dma_valid   : packed beat out; held stable until dma_ready
//   dma_last             : the current beat is the last beat of the frame
//   busy                 : a frame is in progress
//   done                 : one-cycle pulse after the final beat is accepted
//
// Optional feature (macro RESULTS_DMA_TX_FRAME_CNT_EN)
//   Adds the 8-bit output frame_cnt. It counts completed frames, wraps at 255,
//   and steps in the same cycle that done pulses.

`ifndef DMA_RATE
`define DMA_RATE 144
`endif
`ifndef CYCLES_NUM
`define CYCLES_NUM 16
`endif

module results_dma_tx #(
    parameter int DMA_RATE   = `DMA_RATE,
    parameter int CYCLES_NUM = `CYCLES_NUM
) (
    input  logic                gbdt_clk,
    input  logic                gbdt_rst_n,
    input  logic                start,
    input  logic [8:0]          res_data,
    input  logic                res_valid,
    output logic                res_ready,
    output logic [DMA_RATE-1:0] dma_data,
    output logic                dma_valid,
    input  logic                dma_ready,
    output logic                dma_last,
    output logic                busy,
    output logic                done
`ifdef RESULTS_DMA_TX_FRAME_CNT_EN
    ,
    output logic [7:0]          frame_cnt
`endif
);

    localparam int G  = DMA_RATE / 9;
    localparam int LW = $clog2(G) + 1;
    localparam int BW = $clog2(CYCLES_NUM) + 1;
    localparam logic [LW-1:0] LANE_LAST = LW'(G - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(CYCLES_NUM - 1);

    typedef enum logic [1:0] {IDLE, FILL, SEND} state_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       lane_cnt_q, lane_cnt_d;
    logic [BW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [DMA_RATE-1:0] data_q, data_d;
    logic                res_ready_q, res_ready_d;
    logic                dma_valid_q, dma_valid_d;
    logic                dma_last_q, dma_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef RESULTS_DMA_TX_FRAME_CNT_EN
    logic [7:0]          frame_cnt_q, frame_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        beat_cnt_d = beat_cnt_q;
        data_d     = data_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FILL;
                    lane_cnt_d = '0;
                    beat_cnt_d = '0;
                    data_d     = '0;
                end
            end
            FILL: begin
                if (res_valid && res_ready_q) begin
                    // The lane select uses constant indices, so the part-select
                    // can never go past the top of the beat.
                    for (int i = 0; i < G; i++) begin
                        if (lane_cnt_q == LW'(i)) data_d[9*i +: 9] = res_data;
                    end
                    lane_cnt_d = lane_cnt_q + 1'b1;
                    if (lane_cnt_q == LANE_LAST) state_d = SEND;
                end
            end
            SEND: begin
                if (dma_ready) begin
                    if (beat_cnt_q == BEAT_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = FILL;
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        lane_cnt_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The handshake outputs are registered copies of the next state.
        // That way they change on the same edge as the state.
        res_ready_d = (state_d == FILL);
        dma_valid_d = (state_d == SEND);
        dma_last_d  = (state_d == SEND) && (beat_cnt_d == BEAT_LAST);
        busy_d      = (state_d != IDLE);
`ifdef RESULTS_DMA_TX_FRAME_CNT_EN
        frame_cnt_d = done_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
`endif
    end

    always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
        if (!gbdt_rst_n) begin
            state_q     <= IDLE;
            lane_cnt_q  <= '0;
            beat_cnt_q  <= '0;
            data_q      <= '0;
            res_ready_q <= 1'b0;
            dma_valid_q <= 1'b0;
            dma_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef RESULTS_DMA_TX_FRAME_CNT_EN
            frame_cnt_q <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            lane_cnt_q  <= lane_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            data_q      <= data_d;
            res_ready_q <= res_ready_d;
            dma_valid_q <= dma_valid_d;
            dma_last_q  <= dma_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef RESULTS_DMA_TX_FRAME_CNT_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    assign res_ready = res_ready_q;
    assign dma_data  = data_q;
    assign dma_valid = dma_valid_q;
    assign dma_last  = dma_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef RESULTS_DMA_TX_FRAME_CNT_EN
    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_results_dma_tx.sv
// tb_results_dma_tx
//   Drives random and directed traffic into results_dma_tx.
//   It compares every cycle against a count-based model of the frame protocol:
//   how many results have been taken into the current beat, how many beats
//   of the frame are done, and whether a frame is open.
//   Result values come from a running counter, so the order of the packed
//   lanes shows up directly in the expected beat.
module tb_results_dma_tx;
    localparam int DW  = 144;
    localparam int G   = DW / 9;
    localparam int CYC = 16;

    logic          gbdt_clk   = 1'b0;
    logic          gbdt_rst_n = 1'b1;
    logic          start      = 1'b0;
    logic [8:0]    res_data   = '0;
    logic          res_valid  = 1'b0;
    logic          dma_ready  = 1'b0;
    logic          res_ready, dma_valid, dma_last, busy, done;
    logic [DW-1:0] dma_data;
`ifdef RESULTS_DMA_TX_FRAME_CNT_EN
    logic [7:0]    frame_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Model state
    bit         in_frame  = 0;
    bit         done_exp  = 0;
    int         acc       = 0;   // results taken into the current beat
    int         beats     = 0;   // beats of this frame already sent
    int         frames    = 0;   // frames completed since the last reset
    int         done_seen = 0;
    int         next_val  = 0;
    logic [8:0] beat_vals [G];

    results_dma_tx dut (
        .gbdt_clk  (gbdt_clk),
        .gbdt_rst_n(gbdt_rst_n),
        .start     (start),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .dma_data  (dma_data),
        .dma_valid (dma_valid),
        .dma_ready (dma_ready),
        .dma_last  (dma_last),
        .busy      (busy),
        .done      (done)
`ifdef RESULTS_DMA_TX_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 gbdt_clk = ~gbdt_clk;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock cycle. It is called at a negedge with the inputs already set.
    // It checks the outputs, advances the model across the next posedge,
    // and returns at the following negedge.
    task automatic tick();
        logic [DW-1:0] exp_data;
        bit            exp_v;
        res_data = next_val[8:0];
        exp_v    = in_frame && (acc == G);
        chk("res_ready", DW'(res_ready), DW'(in_frame && acc < G));
        chk("dma_valid", DW'(dma_valid), DW'(exp_v));
        chk("dma_last",  DW'(dma_last),  DW'(exp_v && beats == CYC-1));
        chk("busy",      DW'(busy),      DW'(in_frame));
        chk("done",      DW'(done),      DW'(done_exp));
        if (exp_v) begin
            exp_data = '0;
            for (int j = 0; j < G; j++) exp_data[9*j +: 9] = beat_vals[j];
            chk("dma_data", dma_data, exp_data);
        end
`ifdef RESULTS_DMA_TX_FRAME_CNT_EN
        chk("frame_cnt", DW'(frame_cnt), DW'(frames % 256));
`endif
        if (done) done_seen++;

        done_exp = 0;
        if (!in_frame) begin
            if (start) begin
                in_frame = 1;
                acc      = 0;
                beats    = 0;
            end
        end else if (acc < G) begin
            if (res_valid) begin
                beat_vals[acc] = res_data;
                acc++;
                next_val++;
            end
        end else if (dma_ready) begin
            acc = 0;
            if (beats == CYC-1) begin
                in_frame = 0;
                done_exp = 1;
                frames++;
            end else begin
                beats++;
            end
        end
        @(posedge gbdt_clk);
        @(negedge gbdt_clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_frame(input int budget);
        int n;
        n = 0;
        while (in_frame && n < budget) begin
            tick();
            n++;
        end
        chk("frame_timeout", DW'(in_frame), DW'(0));
    endtask

    // Asserts reset in the middle of the low clock phase, so it lands away
    // from any edge. The outputs must clear at once, before any clock edge.
    task automatic do_reset();
        #2 gbdt_rst_n = 1'b0;
        #1;
        chk("rst_dma_data",  dma_data,         DW'(0));
        chk("rst_dma_valid", DW'(dma_valid),   DW'(0));
        chk("rst_dma_last",  DW'(dma_last),    DW'(0));
        chk("rst_res_ready", DW'(res_ready),   DW'(0));
        chk("rst_busy",      DW'(busy),        DW'(0));
        chk("rst_done",      DW'(done),        DW'(0));
`ifdef RESULTS_DMA_TX_FRAME_CNT_EN
        chk("rst_frame_cnt", DW'(frame_cnt),   DW'(0));
`endif
        in_frame  = 0;
        acc       = 0;
        beats     = 0;
        done_exp  = 0;
        frames    = 0;
        start     = 1'b0;
        res_valid = 1'b0;
        dma_ready = 1'b0;
        @(negedge gbdt_clk);
        @(negedge gbdt_clk);
        gbdt_rst_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] k16;
        int            d0;
        int            n;

        @(negedge gbdt_clk);
        do_reset();
        tick();

        // Directed: the first beat carries values 0..15.
        // dma_valid must be up the cycle after the 16th accept.
        next_val  = 0;
        res_valid = 1'b1;
        dma_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < G; i++) tick();
        k16 = '0;
        for (int j = 0; j < G; j++) k16[9*j +: 9] = 9'(j);
        chk("t1_data",  dma_data,        k16);
        chk("t1_valid", DW'(dma_valid),  DW'(1));
        chk("t1_last",  DW'(dma_last),   DW'(0));
        run_frame(400);
        tick();

        // A full frame of 0..255. done must pulse exactly once.
        next_val = 0;
        d0       = done_seen;
        pulse_start();
        run_frame(400);
        tick();
        chk("t2_done_once", DW'(done_seen - d0), DW'(1));

        // Back-pressure: the beat is held through 5 stalled cycles.
        pulse_start();
        dma_ready = 1'b0;
        n = 0;
        while (acc < G && n < 40) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) tick();
        dma_ready = 1'b1;
        run_frame(400);
        tick();

        // Random traffic: res_valid, dma_ready and start are all random.
        // Extra starts land inside frames and must be ignored.
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom % 8) == 0;
            res_valid = $urandom % 2;
            dma_ready = $urandom % 2;
            tick();
        end
        start     = 1'b0;
        res_valid = 1'b1;
        dma_ready = 1'b1;
        run_frame(600);
        tick();

        // Reset after 3 beats plus 7 lanes.
        // The next frame must start cleanly at lane 0, beat 0.
        next_val = 0;
        pulse_start();
        n = 0;
        while (!(beats == 3 && acc == 7) && n < 200) begin
            tick();
            n++;
        end
        do_reset();
        tick();
        tick();
        next_val  = 0;
        res_valid = 1'b1;
        dma_ready = 1'b1;
        pulse_start();
        run_frame(400);
        tick();

`ifdef RESULTS_DMA_TX_FRAME_CNT_EN
        // 257 back-to-back frames: frame_cnt wraps through 0 and ends at 1.
        do_reset();
        start     = 1'b1;
        res_valid = 1'b1;
        dma_ready = 1'b1;
        n = 0;
        while (frames < 257 && n < 80000) begin
            tick();
            n++;
        end
        start = 1'b0;
        chk("t6_frames",    DW'(frames),    DW'(257));
        chk("t6_frame_cnt", DW'(frame_cnt), DW'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/results_dma_tx.md
RESULTS_DMA_TX -- requirements
Module: results_dma_tx

Interface
REQ-001 The block SHALL have parameter DMA_RATE, default `DMA_RATE (144), meaning DMA beat width in bits; it SHALL be a multiple of 9.
REQ-002 The block SHALL have parameter CYCLES_NUM, default `CYCLES_NUM (16), meaning beats per frame.
REQ-003 The block SHALL have port gbdt_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port gbdt_rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port start  input  1  frame start request, sampled in IDLE only.
REQ-006 The block SHALL have port res_data  input  9  result value from the GBDT core.
REQ-007 The block SHALL have port res_valid  input  1  res_data is valid.
REQ-008 The block SHALL have port res_ready  output  1  block accepts res_data this cycle.
REQ-009 The block SHALL have port dma_data  output  DMA_RATE  packed beat to the DMA.
REQ-010 The block SHALL have port dma_valid  output  1  dma_data is valid.
REQ-011 The block SHALL have port dma_ready  input  1  DMA accepts the beat this cycle.
REQ-012 The block SHALL have port dma_last  output  1  current beat is the last beat of the frame.
REQ-013 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-015 The block SHALL implement FSM states IDLE, FILL and SEND, with G = DMA_RATE/9 lanes per beat (16 at defaults).
REQ-016 In IDLE, start SHALL move the FSM to FILL and clear lane_cnt, beat_cnt and the pack register; in FILL and SEND, start SHALL be ignored.
REQ-017 res_ready SHALL equal 1 only in FILL, and a value SHALL be accepted only when res_valid && res_ready.
REQ-018 An accepted value SHALL be written to dma_data[9*lane_cnt +: 9], after which lane_cnt SHALL increment; lane 0 occupies the LSBs.
REQ-019 Acceptance of lane G-1 SHALL move the FSM to SEND, so dma_valid rises the cycle after the G-th accept.
REQ-020 In SEND, dma_valid SHALL be 1 and dma_data SHALL be held stable until dma_ready is sampled high.
REQ-021 dma_valid SHALL NOT drop without dma_ready.
REQ-022 dma_last SHALL equal dma_valid && (beat_cnt == CYCLES_NUM-1).
REQ-023 On SEND && dma_ready with beat_cnt < CYCLES_NUM-1, the block SHALL increment beat_cnt, clear lane_cnt and return to FILL.
REQ-024 On SEND && dma_ready with beat_cnt == CYCLES_NUM-1, the block SHALL go to IDLE and pulse done high for the next cycle.
REQ-025 A start asserted in the done cycle SHALL begin a new frame.
REQ-026 lane_cnt SHALL be $clog2(G)+1 bits wide and beat_cnt $clog2(CYCLES_NUM)+1 bits wide, neither wrapping inside a frame.
REQ-027 res_valid while res_ready=0 SHALL have no effect, and the upstream SHALL hold res_data until it is accepted.
REQ-028 dma_ready outside SEND SHALL have no effect.

Reset
REQ-029 While gbdt_rst_n=0, and immediately on its assertion, the block SHALL be in IDLE with dma_data=0, dma_valid=0, dma_last=0, res_ready=0, busy=0, done=0, lane_cnt=0 and beat_cnt=0.
REQ-030 Reset mid-frame SHALL discard the partial beat and frame, and the block SHALL emit nothing more until the next start.

Configuration
REQ-031 With macro RESULTS_DMA_TX_FRAME_CNT_EN defined, the block SHALL add output port frame_cnt (8 bits, reset value 0).
REQ-032 With RESULTS_DMA_TX_FRAME_CNT_EN defined, frame_cnt SHALL increment in the same cycle done pulses and wrap from 255 to 0.
REQ-033 Without RESULTS_DMA_TX_FRAME_CNT_EN, the frame_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-034 The bench SHALL cover: start, then 16 values 0..15 with res_valid held high and dma_ready=1 -> dma_data = {9'd15,...,9'd1,9'd0}, dma_valid one cycle after the 16th accept, dma_last=0.
REQ-035 The bench SHALL cover: a full frame of 256 values k=0..255 with dma_ready=1 -> 16 beats, beat b lane j = 16b+j, dma_last on beat 15 only, done pulses once, busy drops with done.
REQ-036 The bench SHALL cover: dma_ready held low 5 cycles in SEND -> dma_valid=1 and dma_data unchanged all 5 cycles, res_ready=0, beat accepted on the first dma_ready=1.
REQ-037 The bench SHALL cover: res_valid toggled randomly and start pulsed mid-frame -> value order preserved, no lane skipped or duplicated, start ignored.
REQ-038 The bench SHALL cover: gbdt_rst_n pulsed low after 3 beats plus 7 lanes -> all outputs 0 at once; a following start and 256 values give a clean frame starting at lane 0, beat 0.
REQ-039 The bench SHALL cover, with RESULTS_DMA_TX_FRAME_CNT_EN: 257 back-to-back frames -> frame_cnt reads 1 after the 257th frame.
